// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone register-bus arbiter.
package wb_arb_pkg;

  localparam int NM_MAX    = 4;
  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_t;

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after index 'last',
// wrapping modulo NM. One-hot result, zero when nothing is requested.
module rr_pick #(
  parameter int NM = 2,
  parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [NM-1:0] gnt
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NM; i++) begin
      idx = (32'(last) + i) % NM;
      for (int unsigned k = 0; k < NM; k++) begin
        if (!found && k == idx && req[k]) begin
          gnt[k] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: one master owns the slave per bus cycle,
// with error termination of accesses the slave never acknowledges.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [NM-1:0]    m_cyc_i,
  input  logic [NM-1:0]    m_stb_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*AW-1:0] m_adr_i,
  input  logic [NM*DW-1:0] m_dat_i,
  output logic [DW-1:0]    m_dat_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NM-1:0]    gnt_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [AW-1:0]    s_adr_o,
  output logic [DW-1:0]    s_dat_o,
  input  logic [DW-1:0]    s_dat_i,
  input  logic             s_ack_i
);

  localparam int LW = (NM > 1) ? $clog2(NM) : 1;

  state_t               state, state_nxt;
  logic [NM-1:0]        gnt, gnt_nxt, req, pick;
  logic [LW-1:0]        last_gnt, last_nxt, pick_idx;
  logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
  logic                 cyc_g, stb_g, we_g, timeout;
  logic [AW-1:0]        adr_g;
  logic [DW-1:0]        dat_g;

  assign req = m_cyc_i & m_stb_i;

  rr_pick #(.NM(NM)) u_pick (
    .req  (req),
    .last (last_gnt),
    .gnt  (pick)
  );

  // last_gnt doubles as the current owner index while BUSY/ERR
  always_comb begin
    cyc_g    = 1'b0;
    stb_g    = 1'b0;
    we_g     = 1'b0;
    adr_g    = '0;
    dat_g    = '0;
    pick_idx = '0;
    for (int unsigned k = 0; k < NM; k++) begin
      if (LW'(k) == last_gnt) begin
        cyc_g = m_cyc_i[k];
        stb_g = m_stb_i[k];
        we_g  = m_we_i[k];
        adr_g = m_adr_i[k*AW +: AW];
        dat_g = m_dat_i[k*DW +: DW];
      end
      if (pick[k]) pick_idx = LW'(k);
    end
  end

  assign timeout = (state == BUSY) && stb_g && !s_ack_i &&
                   (cnt == TIMEOUT_W'(TIMEOUT));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= LW'(NM - 1);
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last_gnt;
    cnt_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt   = pick;
          last_nxt  = pick_idx;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (timeout) begin
          state_nxt = ERR;
        end else if (!cyc_g) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end else if (stb_g && !s_ack_i) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ERR: begin
        if (!cyc_g) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state == BUSY) begin
      s_cyc_o = cyc_g;
      s_stb_o = stb_g;
      s_we_o  = we_g;
      s_adr_o = adr_g;
      s_dat_o = dat_g;
      for (int unsigned k = 0; k < NM; k++) begin
        if (LW'(k) == last_gnt) begin
          m_ack_o[k] = s_ack_i & stb_g;
          m_err_o[k] = timeout;
        end
      end
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt;

endmodule
